// File: rtl/mem_dump_reader.sv
// mem_dump_reader: post-run readback engine for the data RAM read port.
// Reads a window of word addresses through a 1-cycle-latency synchronous RAM
// port and streams them out on a valid/ready interface with a last flag.
module mem_dump_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]       DepthL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]       CntOne  = (PW+1)'(1);
  localparam logic [PW-1:0]     PtrOne  = PW'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WordOne = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] nextAddr_q, nextAddr_d;
  logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
  logic [ADDR_W:0]   issueRem_q, issueRem_d;
  logic [ADDR_W:0]   popRem_q, popRem_d;
  logic              inflight_q;
  logic [DATA_W-1:0] fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]     wrPtr_q, rdPtr_q;
  logic [PW:0]       count_q, count_d;
  logic [PW:0]       occupancy;
  logic              push, pop;

  // Occupancy counts words already buffered plus the read still in flight,
  // so issuing only below FIFO_DEPTH means the buffer can never overflow.
  assign occupancy = count_q + {{PW{1'b0}}, inflight_q};
  assign push      = inflight_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count_q != '0);
  assign out_data  = fifoMem_q[rdPtr_q];
  assign out_last  = out_valid && (popRem_q == WordOne);
  assign mem_addr  = mem_re ? nextAddr_q : lastAddr_q;

  // Next-state, read-issue and status decode for the dump sequencer.
  always_comb begin
    state_d    = state_q;
    nextAddr_d = nextAddr_q;
    lastAddr_d = lastAddr_q;
    issueRem_d = issueRem_q;
    popRem_d   = popRem_q;
    mem_re     = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d    = READ;
            nextAddr_d = base_addr;
            issueRem_d = length;
            popRem_d   = length;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        mem_re = (issueRem_q != '0) && (occupancy < DepthL);
        if (mem_re) begin
          nextAddr_d = nextAddr_q + AddrOne;
          lastAddr_d = nextAddr_q;
          issueRem_d = issueRem_q - WordOne;
        end
        if (pop) begin
          popRem_d = popRem_q - WordOne;
          if (out_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer occupancy follows push/pop; both at once leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Sequencer registers; reset aborts any dump without a done pulse.
  always_ff @(posedge clk) begin
    if (!Rstn) begin
      state_q    <= IDLE;
      nextAddr_q <= '0;
      lastAddr_q <= '0;
      issueRem_q <= '0;
      popRem_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nextAddr_q <= nextAddr_d;
      lastAddr_q <= lastAddr_d;
      issueRem_q <= issueRem_d;
      popRem_q   <= popRem_d;
      inflight_q <= mem_re;
    end
  end

  // Output buffer: RAM data lands the cycle after its read; reset drops it.
  always_ff @(posedge clk) begin
    if (!Rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= mem_rdata;
        wrPtr_q            <= wrPtr_q + PtrOne;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PtrOne;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
Post-run readback engine for the data RAM. On a start pulse it sequentially reads a window of word addresses from a synchronous-read RAM port with 1-cycle latency. It streams the words out on a valid/ready interface with a last flag, so a bench or host link can read back results the program wrote. It sits beside the data memory on its second (read) port, and is the counterpart of the memory-initialisation path.

Parameters:
ADDR_W, 10, word-address width of the RAM; window addresses wrap modulo 2^ADDR_W.
DATA_W, 32, RAM word width.
FIFO_DEPTH, 4, output buffer entries (power of 2, >=2).

Ports:
clk  input  1  system clock, rising edge.
Rstn  input  1  synchronous active-low reset.
start  input  1  begin a dump; sampled only in IDLE.
base_addr  input  ADDR_W  first word address; captured on accepted start.
length  input  ADDR_W+1  number of words, 0..2^ADDR_W; captured on accepted start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  single-cycle pulse at end of dump.
mem_re  output  1  RAM read enable.
mem_addr  output  ADDR_W  RAM read address.
mem_rdata  input  DATA_W  RAM data, valid the cycle after mem_re.
out_valid  output  1  stream word valid.
out_data  output  DATA_W  stream word.
out_last  output  1  marks final word; qualified by out_valid.
out_ready  input  1  downstream accept.

Behaviour:
- One clock: clk. Reset is synchronous and active-low: Rstn=0 at a rising edge clears every register. While in reset: busy=0, done=0, mem_re=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, FIFO empty, state IDLE. Reset mid-dump aborts it with no done pulse, and in-flight read data is discarded.
- FSM states: IDLE, READ, DONE.
  - IDLE: start=1 with length!=0 -> READ; capture base/length, issue counter=length, pop counter=length. start=1 with length==0 -> DONE.
  - READ: exit to DONE on the handshake (out_valid&out_ready) of the word with out_last=1.
  - DONE: done=1 for exactly this cycle, then IDLE. start is ignored in READ and DONE.
- Issue rule: in READ, mem_re=1 when issue counter>0 and fifo_count+inflight < FIFO_DEPTH. inflight is the registered mem_re of the previous cycle.
  - No combinational path from out_ready to mem_re.
  - mem_addr = base + issued count, ADDR_W-bit wrap. mem_addr holds its last value when mem_re=0.
- Capture: the cycle after mem_re, mem_rdata is pushed into the FIFO at that clock edge. The FIFO can never overflow by construction.
- Output: out_valid=!fifo_empty. out_data is the FIFO head. out_last=1 when the head is word number length-1. A pop occurs on out_valid&out_ready.
- Stream rules:
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - Words are never dropped or duplicated, and order equals address order.
  - Simultaneous push and pop in one cycle is legal and count is unchanged.
- Latency: start sampled at edge T.
  - First mem_re is in cycle T+1.
  - First out_valid is in cycle T+3.
  - With out_ready held high, one word per cycle.
  - done occurs in the cycle after the last handshake.
- busy=1 in READ and DONE. Counters are ADDR_W+1 bits, so length=2^ADDR_W dumps the whole RAM.

Test Plan:
- Reset: hold Rstn=0 two edges mid-idle -> all outputs 0. Release, start, length=1, base=0 -> one word out with out_last=1, then a done pulse.
- Basic: RAM[i]=0xA5000000+i. start at T, base=0x010, length=4, out_ready=1.
  - mem_re in T+1..T+4, addresses 0x010..0x013.
  - out_data 0xA5000010..0xA5000013 in T+3..T+6, out_last only in T+6.
  - done=1 in T+7, busy=0 at T+8.
- Backpressure: base=0x020, length=8, out_ready=0 for 10 cycles then 1.
  - mem_re stops after exactly 4 reads while ready is low, with out_data held at 0xA5000020.
  - All 8 words are delivered in order with no gaps or duplicates.
- Wrap: base=0x3FE, length=4 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001. Data order matches.
- Zero length / ignored start: length=0 -> done at T+1, no mem_re, no out_valid. A start pulse during READ does not change base, count or output sequence.
- Abort: Rstn=0 for one edge after 2 of 6 words are delivered.
  - Next cycle all outputs are 0, with no done pulse and no stray out_valid.
  - A fresh start with base=0x040, length=2 delivers 0xA5000040 and 0xA5000041.
